// File: rtl/cmos_capture_pkg.sv
// Shared camera-path constants (frame geometry, pixel width) and the capture state type.
package cmos_pkg;

  localparam int H_AP_DEF        = 1280;
  localparam int V_AP_DEF        = 720;
  localparam int SKIP_FRAMES_DEF = 10;
  localparam int PIX_W           = 16;
  localparam int BYTE_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// DVP byte input and 16-bit framed pixel output of the capture block.
interface cmos_capture_if;
  import cmos_pkg::*;

  logic              vsync;
  logic              href;
  logic [BYTE_W-1:0] din;
  logic [PIX_W-1:0]  dout;
  logic              dout_sop;
  logic              dout_eop;
  logic              dout_vld;

  modport master (
    output vsync, href, din,
    input  dout, dout_sop, dout_eop, dout_vld
  );

  modport slave (
    input  vsync, href, din,
    output dout, dout_sop, dout_eop, dout_vld
  );

endinterface

// File: rtl/cmos_capture.sv
// DVP RGB565 byte pairing into 16-bit pixels with sop/eop framing, armed on vsync edges.
// Optional CAPTURE_FRAME_SKIP_EN: discard SKIP_FRAMES frames after arming.
//
//   state      | meaning
//   ST_IDLE    | disarmed, waiting for a vsync rise with enable=1
//   ST_SKIP    | armed, discarding frames until the skip counter terminates
//   ST_CAPTURE | emitting pixels; disarms at a vsync rise with enable=0
module cmos_capture
  import cmos_pkg::*;
#(
  parameter int H_AP        = H_AP_DEF,
  parameter int V_AP        = V_AP_DEF,
  parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  cmos_capture_if.slave bus
);

  localparam int COL_W = clog2_min1(H_AP + 1);
  localparam int ROW_W = clog2_min1(V_AP + 1);

  localparam logic [COL_W-1:0] COL_END  = COL_W'(H_AP);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_AP - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_AP);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_AP - 1);

  if (H_AP < 1 || V_AP < 1 || SKIP_FRAMES < 0) begin : g_param_check
    $error("cmos_capture: H_AP and V_AP must be >= 1, SKIP_FRAMES >= 0");
  end

  cap_state_e        state, state_nxt;
  logic              vsync_d, href_d;
  logic              vs_rise, href_fall;
  logic              capture_on;
  logic              phase;
  logic [BYTE_W-1:0] high_byte;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              line_seen;
  logic              pix_emit;
  logic [PIX_W-1:0]  dout_q;
  logic              vld_q, sop_q, eop_q;

  assign vs_rise    = bus.vsync & ~vsync_d;
  assign href_fall  = href_d & ~bus.href;
  assign capture_on = (state == ST_CAPTURE);
  assign pix_emit   = capture_on & bus.href & phase & (col < COL_END) & (row < ROW_END);

`ifdef CAPTURE_FRAME_SKIP_EN
  localparam int SKIP_W = clog2_min1(SKIP_FRAMES + 1);

  logic [SKIP_W-1:0] skip_cnt;
  logic              skip_load, skip_dec, skip_tc;

  assign skip_tc = (skip_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst_n)
      skip_cnt <= '0;
    else if (!enable)
      skip_cnt <= '0;
    else if (skip_load)
      skip_cnt <= SKIP_W'(SKIP_FRAMES - 1);
    else if (skip_dec)
      skip_cnt <= skip_cnt - SKIP_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef CAPTURE_FRAME_SKIP_EN
    skip_load = 1'b0;
    skip_dec  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (vs_rise && enable) begin
`ifdef CAPTURE_FRAME_SKIP_EN
          if (SKIP_FRAMES == 0) begin
            state_nxt = ST_CAPTURE;
          end else begin
            state_nxt = ST_SKIP;
            skip_load = 1'b1;
          end
`else
          state_nxt = ST_CAPTURE;
`endif
        end
      end
`ifdef CAPTURE_FRAME_SKIP_EN
      ST_SKIP: begin
        if (!enable)
          state_nxt = ST_IDLE;
        else if (vs_rise) begin
          if (skip_tc)
            state_nxt = ST_CAPTURE;
          else
            skip_dec = 1'b1;
        end
      end
`endif
      ST_CAPTURE: begin
        if (vs_rise && !enable)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters only advance on emitted pixels and saturate past the frame edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vsync_d   <= 1'b0;
      href_d    <= 1'b0;
      phase     <= 1'b0;
      high_byte <= '0;
      col       <= '0;
      row       <= '0;
      line_seen <= 1'b0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      vsync_d <= bus.vsync;
      href_d  <= bus.href;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      if (vs_rise) begin
        phase     <= 1'b0;
        col       <= '0;
        row       <= '0;
        line_seen <= 1'b0;
      end else if (bus.href) begin
        phase <= ~phase;
        if (!phase) begin
          high_byte <= bus.din;
        end else if (pix_emit) begin
          dout_q    <= {high_byte, bus.din};
          vld_q     <= 1'b1;
          sop_q     <= (col == '0) && (row == '0);
          eop_q     <= (col == COL_LAST) && (row == ROW_LAST);
          col       <= col + COL_W'(1);
          line_seen <= 1'b1;
        end
      end else begin
        phase <= 1'b0;
        if (href_fall) begin
          col       <= '0;
          line_seen <= 1'b0;
          if (line_seen && (row < ROW_END))
            row <= row + ROW_W'(1);
        end
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.dout_sop = sop_q;
  assign bus.dout_eop = eop_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture on a 4x2 frame: pairing, latency, framing, gating, overrun.
module tb_cmos_capture;
  import cmos_pkg::*;

  localparam int H = 4;
  localparam int V = 2;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   stray = 0;
  pix_t q[$];
  int   lat_q[$];

  cmos_capture_if bus();

  cmos_capture #(.H_AP(H), .V_AP(V), .SKIP_FRAMES(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dout_vld === 1'b1)
      q.push_back('{bus.dout, bus.dout_sop, bus.dout_eop, cyc});
    else if (bus.dout_sop !== 1'b0 || bus.dout_eop !== 1'b0)
      stray++;
  end

  function automatic logic [15:0] px(input logic [7:0] base, input logic [7:0] step, input int j);
    logic [7:0] a, b;
    a = base + 8'(2 * j) * step;
    b = base + 8'(2 * j + 1) * step;
    return {a, b};
  endfunction

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.vsync = v;
    bus.href  = h;
    bus.din   = d;
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, base + 8'(i) * step);
      if (i % 2 == 1) lat_q.push_back(cyc);
    end
    repeat (3) drive(1'b0, 1'b0, 8'h00);
  endtask

  function automatic int count_sop();
    int n = 0;
    foreach (q[i]) if (q[i].sop) n++;
    return n;
  endfunction

  function automatic int count_eop();
    int n = 0;
    foreach (q[i]) if (q[i].eop) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b1;
    enable    = 1'b0;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.din   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.href = ~bus.href;
      bus.din  = 8'hA5 + 8'(i);
      @(negedge clk);
      checks++;
      if ({bus.dout, bus.dout_vld, bus.dout_sop, bus.dout_eop} !== 19'h0) begin
        errors++;
        $display("FAIL reset[%0d]: dout=%h vld=%b sop=%b eop=%b, expected all zero",
                 i, bus.dout, bus.dout_vld, bus.dout_sop, bus.dout_eop);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_pairing();
    enable = 1'b1;
    vsync_pulse();
    q.delete();
    lat_q.delete();
    send_line(2 * H, 8'h12, 8'h22);
    checks++;
    if (q.size() !== H) begin
      errors++;
      $display("FAIL pairing_count: got %0d pixels, expected %0d", q.size(), H);
    end
    for (int j = 0; j < H && j < q.size(); j++) begin
      checks++;
      if (q[j].data !== px(8'h12, 8'h22, j)) begin
        errors++;
        $display("FAIL pairing_data[%0d]: got %h, expected %h", j, q[j].data, px(8'h12, 8'h22, j));
      end
      checks++;
      if (q[j].cyc !== lat_q[j] + 1) begin
        errors++;
        $display("FAIL pairing_latency[%0d]: vld at cycle %0d, expected %0d", j, q[j].cyc, lat_q[j] + 1);
      end
    end
    send_line(2 * H, 8'h01, 8'h01);
    checks++;
    if (q.size() !== H * V) begin
      errors++;
      $display("FAIL pairing_frame_count: got %0d pixels, expected %0d", q.size(), H * V);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] b0, input logic [7:0] b1);
    checks++;
    if (q.size() !== H * V) begin
      errors++;
      $display("FAIL %s_count: got %0d pixels, expected %0d", name, q.size(), H * V);
    end else begin
      checks++;
      if (q[0].sop !== 1'b1 || q[0].data !== px(b0, 8'h01, 0)) begin
        errors++;
        $display("FAIL %s_sop: first pixel sop=%b data=%h, expected sop=1 data=%h",
                 name, q[0].sop, q[0].data, px(b0, 8'h01, 0));
      end
      checks++;
      if (q[H*V-1].eop !== 1'b1 || q[H*V-1].data !== px(b1, 8'h01, H - 1)) begin
        errors++;
        $display("FAIL %s_eop: last pixel eop=%b data=%h, expected eop=1 data=%h",
                 name, q[H*V-1].eop, q[H*V-1].data, px(b1, 8'h01, H - 1));
      end
      checks++;
      if (q[H].data !== px(b1, 8'h01, 0)) begin
        errors++;
        $display("FAIL %s_row1: got %h, expected %h", name, q[H].data, px(b1, 8'h01, 0));
      end
    end
    checks++;
    if (count_sop() !== 1 || count_eop() !== 1) begin
      errors++;
      $display("FAIL %s_flags: sop count=%0d eop count=%0d, expected 1 and 1", name, count_sop(), count_eop());
    end
  endtask

  task automatic test_framing();
    for (int f = 0; f < 2; f++) begin
      vsync_pulse();
      q.delete();
      send_line(2 * H, 8'h20 + 8'(f * 64), 8'h01);
      send_line(2 * H, 8'h30 + 8'(f * 64), 8'h01);
      check_frame($sformatf("framing%0d", f), 8'h20 + 8'(f * 64), 8'h30 + 8'(f * 64));
    end
  endtask

  task automatic test_enable_gating();
    enable = 1'b0;
    vsync_pulse();
    q.delete();
    send_line(2 * H, 8'h50, 8'h01);
    enable = 1'b1;
    send_line(2 * H, 8'h60, 8'h01);
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL gating_idle: got %0d pixels while disarmed, expected 0", q.size());
    end
    vsync_pulse();
    q.delete();
    send_line(2 * H, 8'h70, 8'h01);
    send_line(2 * H, 8'h78, 8'h01);
    check_frame("gating", 8'h70, 8'h78);
  endtask

  task automatic test_short_frame();
    vsync_pulse();
    q.delete();
    send_line(2 * H, 8'h80, 8'h01);
    vsync_pulse();
    checks++;
    if (q.size() !== H || count_eop() !== 0) begin
      errors++;
      $display("FAIL short_frame: got %0d pixels, %0d eop, expected %0d pixels, 0 eop", q.size(), count_eop(), H);
    end
    q.delete();
    send_line(2 * H, 8'h90, 8'h01);
    send_line(2 * H, 8'hA0, 8'h01);
    check_frame("after_short", 8'h90, 8'hA0);
  endtask

  task automatic test_overrun();
    vsync_pulse();
    q.delete();
    send_line(2 * H + 1, 8'hB0, 8'h01);
    send_line(2 * H + 1, 8'hC0, 8'h01);
    send_line(2 * H + 1, 8'hD0, 8'h01);
    check_frame("overrun", 8'hB0, 8'hC0);
    @(negedge clk);
    checks++;
    if (bus.dout !== px(8'hC0, 8'h01, H - 1) || bus.dout_vld !== 1'b0) begin
      errors++;
      $display("FAIL overrun_hold: dout=%h vld=%b, expected dout=%h vld=0",
               bus.dout, bus.dout_vld, px(8'hC0, 8'h01, H - 1));
    end
  endtask

  initial begin
    test_reset();
    test_pairing();
    test_framing();
    test_enable_gating();
    test_short_frame();
    test_overrun();
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL stray_flags: %0d sop/eop without vld, expected 0", stray);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
